// File: rtl/pc_seq.sv
// Program-counter sequencer: PC register, control-flow decode, jump-unit mode select
// and a hardware return-address stack. Optional overflow/underflow trap: PC_SEQ_FAULT_EN.
module pc_seq #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic             zf,
    input  logic [WIDTH-1:0] tgt,
    input  logic             resume,
    output logic [WIDTH-1:0] pc,
    output logic [1:0]       jmp_mode,
    output logic [WIDTH-1:0] lr_addr,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             halted,
    output logic             fault
);

    localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SPW = AW + 1;
    localparam logic [SPW-1:0] SP_MAX = SPW'(STACK_DEPTH);

    localparam logic [2:0] OP_NEXT = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JZ   = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b101;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_TGT  = 2'b01;
    localparam logic [1:0] MODE_LR   = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HALTED = 2'b01,
        ST_FAULT  = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_nxt_s;
    logic [WIDTH-1:0] pc_inc_s;
    logic [SPW-1:0]   sp_r;
    logic [SPW-1:0]   sp_nxt_s;
    logic [WIDTH-1:0] stack_r [STACK_DEPTH];
    logic             push_s;
    logic             empty_s;
    logic             full_s;
    logic [AW-1:0]    top_idx_s;
    logic [AW-1:0]    push_idx_s;
    logic             halted_s;
    logic             fault_s;

    assign pc_inc_s   = pc_r + WIDTH'(1);
    assign empty_s    = (sp_r == SPW'(0));
    assign full_s     = (sp_r == SP_MAX);
    assign top_idx_s  = AW'(sp_r - SPW'(1));
    assign push_idx_s = sp_r[AW-1:0];

    // State register of the RUN/HALTED/FAULT machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; nothing moves while en is low.
    always_comb begin
        state_nxt_s = state_r;
        if (en) begin
            case (state_r)
                ST_RUN: begin
                    if (op == OP_HALT) begin
                        state_nxt_s = ST_HALTED;
`ifdef PC_SEQ_FAULT_EN
                    end else if (((op == OP_CALL) && full_s) || ((op == OP_RET) && empty_s)) begin
                        state_nxt_s = ST_FAULT;
`endif
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_HALTED;
                    end
                end
`ifdef PC_SEQ_FAULT_EN
                ST_FAULT:  state_nxt_s = ST_FAULT;
`endif
                default:   state_nxt_s = ST_RUN;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State-decoded status outputs.
    always_comb begin
        halted_s = 1'b0;
        fault_s  = 1'b0;
        case (state_r)
            ST_HALTED: halted_s = 1'b1;
`ifdef PC_SEQ_FAULT_EN
            ST_FAULT:  fault_s  = 1'b1;
`endif
            default: begin
                halted_s = 1'b0;
                fault_s  = 1'b0;
            end
        endcase
    end

    // PC / stack-pointer next values and push request for the current op.
    always_comb begin
        pc_nxt_s = pc_r;
        sp_nxt_s = sp_r;
        push_s   = 1'b0;
        if (en && (state_r == ST_RUN)) begin
            case (op)
                OP_NEXT: pc_nxt_s = pc_inc_s;
                OP_JMP:  pc_nxt_s = tgt;
                OP_JZ: begin
                    if (zf) begin
                        pc_nxt_s = tgt;
                    end else begin
                        pc_nxt_s = pc_inc_s;
                    end
                end
                OP_CALL: begin
                    if (full_s) begin
`ifdef PC_SEQ_FAULT_EN
                        pc_nxt_s = pc_r;
`else
                        // Full stack: the jump still happens, the return address is lost.
                        pc_nxt_s = tgt;
`endif
                    end else begin
                        pc_nxt_s = tgt;
                        sp_nxt_s = sp_r + SPW'(1);
                        push_s   = 1'b1;
                    end
                end
                OP_RET: begin
                    if (empty_s) begin
`ifdef PC_SEQ_FAULT_EN
                        pc_nxt_s = pc_r;
`else
                        pc_nxt_s = tgt;
`endif
                    end else begin
                        pc_nxt_s = tgt;
                        sp_nxt_s = sp_r - SPW'(1);
                    end
                end
                OP_HALT: pc_nxt_s = pc_r;
                default: pc_nxt_s = pc_inc_s;
            endcase
        end else if (en && (state_r == ST_HALTED) && resume) begin
            pc_nxt_s = pc_inc_s;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // PC and stack-pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= '0;
            sp_r <= '0;
        end else begin
            pc_r <= pc_nxt_s;
            sp_r <= sp_nxt_s;
        end
    end

    // Return-address stack storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_r[i] <= '0;
            end
        end else if (push_s) begin
            stack_r[push_idx_s] <= pc_inc_s;
        end else begin
            stack_r <= stack_r;
        end
    end

    // Jump-unit mode follows op alone so the target is ready in the same cycle.
    always_comb begin
        case (op)
            OP_JMP, OP_JZ, OP_CALL: jmp_mode = MODE_TGT;
            OP_RET:                 jmp_mode = MODE_LR;
            default:                jmp_mode = MODE_NONE;
        endcase
    end

    assign pc          = pc_r;
    assign lr_addr     = empty_s ? WIDTH'(0) : stack_r[top_idx_s];
    assign stack_empty = empty_s;
    assign stack_full  = full_s;
    assign halted      = halted_s;
    assign fault       = fault_s;

endmodule

// File: tb/tb_pc_seq.sv
// Directed self-checking bench for pc_seq; expectations follow PC_SEQ_FAULT_EN when defined.
module tb_pc_seq;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] op;
    logic       zf;
    logic [7:0] tgt;
    logic       resume;
    logic [7:0] pc;
    logic [1:0] jmp_mode;
    logic [7:0] lr_addr;
    logic       stack_empty;
    logic       stack_full;
    logic       halted;
    logic       fault;

    int total;
    int bad;

    pc_seq #(.WIDTH(8), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .op(op), .zf(zf), .tgt(tgt),
        .resume(resume), .pc(pc), .jmp_mode(jmp_mode), .lr_addr(lr_addr),
        .stack_empty(stack_empty), .stack_full(stack_full),
        .halted(halted), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [7:0] t);
        op  = o;
        tgt = t;
        #1;
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; en = 1'b0; op = 3'b000; zf = 1'b0; tgt = 8'h00; resume = 1'b0;
        #12;
        chk("rst_pc", pc, 8'h00);
        chk("rst_halted", halted, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_empty", stack_empty, 1'b1);
        chk("rst_full", stack_full, 1'b0);
        chk("rst_lr", lr_addr, 8'h00);
        rst_n = 1'b1;
        en = 1'b1;

        drive(3'b000, 8'h00);
        chk("mode_next", jmp_mode, 2'b00);
        step(); chk("next1", pc, 8'h01);
        step(); chk("next2", pc, 8'h02);
        step(); chk("next3", pc, 8'h03);
        chk("run_halted", halted, 1'b0);
        chk("run_fault", fault, 1'b0);

        drive(3'b001, 8'hA7);
        chk("mode_jmp", jmp_mode, 2'b01);
        step(); chk("jmp", pc, 8'hA7);
        zf = 1'b0; drive(3'b010, 8'h12);
        chk("mode_jz", jmp_mode, 2'b01);
        step(); chk("jz_nt", pc, 8'hA8);
        zf = 1'b1; step(); chk("jz_t", pc, 8'h12);
        zf = 1'b0;

        drive(3'b001, 8'h10); step(); chk("jmp10", pc, 8'h10);
        drive(3'b011, 8'h40);
        chk("mode_call", jmp_mode, 2'b01);
        step();
        chk("call_pc", pc, 8'h40);
        chk("call_lr", lr_addr, 8'h11);
        chk("call_empty", stack_empty, 1'b0);
        drive(3'b100, 8'h11);
        chk("mode_ret", jmp_mode, 2'b11);
        step();
        chk("ret_pc", pc, 8'h11);
        chk("ret_empty", stack_empty, 1'b1);
        chk("ret_lr", lr_addr, 8'h00);

        drive(3'b011, 8'h20); step(); chk("c1_lr", lr_addr, 8'h12);
        drive(3'b011, 8'h30); step(); chk("c2_lr", lr_addr, 8'h21);
        drive(3'b011, 8'h40); step(); chk("c3_lr", lr_addr, 8'h31);
        chk("c3_full", stack_full, 1'b0);
        drive(3'b011, 8'h50); step();
        chk("c4_pc", pc, 8'h50);
        chk("c4_lr", lr_addr, 8'h41);
        chk("c4_full", stack_full, 1'b1);
        drive(3'b011, 8'h60); step();
`ifdef PC_SEQ_FAULT_EN
        chk("ovf_fault", fault, 1'b1);
        chk("ovf_pc", pc, 8'h50);
        chk("ovf_full", stack_full, 1'b1);
        drive(3'b000, 8'h00); step();
        chk("fault_frozen", pc, 8'h50);
        rst_n = 1'b0; #2;
        chk("arst_pc", pc, 8'h00);
        chk("arst_fault", fault, 1'b0);
        chk("arst_empty", stack_empty, 1'b1);
        rst_n = 1'b1;
        drive(3'b100, 8'h77); step();
        chk("unf_fault", fault, 1'b1);
        chk("unf_pc", pc, 8'h00);
        rst_n = 1'b0; #2;
        chk("arst2_fault", fault, 1'b0);
        rst_n = 1'b1;
`else
        chk("ovf_fault", fault, 1'b0);
        chk("ovf_pc", pc, 8'h60);
        chk("ovf_full", stack_full, 1'b1);
        chk("ovf_lr", lr_addr, 8'h41);
        drive(3'b100, 8'h41); step();
        chk("r4_lr", lr_addr, 8'h31);
        chk("r4_full", stack_full, 1'b0);
        drive(3'b100, 8'h31); step(); chk("r3_lr", lr_addr, 8'h21);
        drive(3'b100, 8'h21); step(); chk("r2_lr", lr_addr, 8'h12);
        drive(3'b100, 8'h12); step(); chk("r1_empty", stack_empty, 1'b1);
        drive(3'b100, 8'h77); step();
        chk("unf_pc", pc, 8'h77);
        chk("unf_empty", stack_empty, 1'b1);
        chk("unf_fault", fault, 1'b0);
        drive(3'b011, 8'h05); step();
        chk("push_after_unf", lr_addr, 8'h78);
        rst_n = 1'b0; #2;
        chk("arst_pc", pc, 8'h00);
        chk("arst_empty", stack_empty, 1'b1);
        chk("arst_fault", fault, 1'b0);
        rst_n = 1'b1;
`endif

        drive(3'b001, 8'hFF); step(); chk("jmpff", pc, 8'hFF);
        drive(3'b000, 8'h00); step(); chk("wrap", pc, 8'h00);
        drive(3'b011, 8'h08); step(); chk("wrap_lr", lr_addr, 8'h01);
        drive(3'b001, 8'hFF); step();
        drive(3'b011, 8'h09); step(); chk("push_wrap_lr", lr_addr, 8'h00);
        drive(3'b101, 8'h00);
        chk("mode_halt", jmp_mode, 2'b00);
        step();
        chk("halt_halted", halted, 1'b1);
        chk("halt_pc", pc, 8'h09);
        drive(3'b001, 8'h33);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("halt_hold_pc", pc, 8'h09);
            chk("halt_hold", halted, 1'b1);
        end
        en = 1'b0; resume = 1'b1; step();
        chk("resume_en0", halted, 1'b1);
        chk("resume_en0_pc", pc, 8'h09);
        en = 1'b1; step();
        chk("resume_pc", pc, 8'h0A);
        chk("resume_halted", halted, 1'b0);
        drive(3'b000, 8'h00); step();
        chk("resume_in_run", pc, 8'h0B);
        resume = 1'b0;

        en = 1'b0;
        drive(3'b001, 8'h99); step(); chk("en0_jmp", pc, 8'h0B);
        drive(3'b100, 8'h99); step();
        chk("en0_ret_pc", pc, 8'h0B);
        chk("en0_ret_lr", lr_addr, 8'h00);
        drive(3'b101, 8'h00); step(); chk("en0_halt", halted, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
